// File: rtl/cpu_run_controller.sv
// Bounded run/step controller: gates the CPU clock-enable for N cycles, a
// single step, or until halt, then parks in DONE with a cycle count and reason.
module cpu_run_controller #(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_CYCLES = 4
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Step,
  input  logic [CNT_W-1:0] Cycles,
  input  logic             Abort,
  input  logic             Halt_in,
  output logic             CpuEn,
  output logic             Busy,
  output logic             Done,
  output logic [CNT_W-1:0] CycleCount,
  output logic [1:0]       StopReason
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ZERO          = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE           = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] DEFAULT_LIMIT = CNT_W'(DEFAULT_CYCLES);

  localparam logic [1:0] REASON_LIMIT = 2'b00;
  localparam logic [1:0] REASON_HALT  = 2'b01;
  localparam logic [1:0] REASON_ABORT = 2'b10;
  localparam logic [1:0] REASON_STEP  = 2'b11;

  // Step accumulation must not wrap, so it sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      sat_inc = value;
    end else begin
      sat_inc = value + ONE;
    end
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] limit_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       reason_r;
  logic             cpu_en_r;
  logic             busy_r;
  logic             done_r;

  logic [CNT_W-1:0] count_inc_s;
  logic [CNT_W-1:0] limit_sel_s;

  // Next-count and start-time limit selection.
  always_comb begin
    count_inc_s = count_r + ONE;
    if (Cycles == ZERO) begin
      limit_sel_s = DEFAULT_LIMIT;
    end else begin
      limit_sel_s = Cycles;
    end
  end

  // State machine with registered Moore outputs.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r  <= ST_IDLE;
      limit_r  <= ZERO;
      count_r  <= ZERO;
      reason_r <= REASON_LIMIT;
      cpu_en_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (Start) begin
            state_r  <= ST_RUN;
            count_r  <= ZERO;
            limit_r  <= limit_sel_s;
            cpu_en_r <= 1'b1;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
          end else if (Step) begin
            state_r  <= ST_STEP;
            cpu_en_r <= 1'b1;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
          end else begin
            cpu_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= (state_r == ST_DONE);
          end
        end
        ST_RUN: begin
          // The deciding cycle was enabled, so it is always counted.
          count_r <= count_inc_s;
          if (Abort || Halt_in || (count_inc_s == limit_r)) begin
            state_r  <= ST_DONE;
            cpu_en_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            if (Abort) begin
              reason_r <= REASON_ABORT;
            end else if (Halt_in) begin
              reason_r <= REASON_HALT;
            end else begin
              reason_r <= REASON_LIMIT;
            end
          end else begin
            cpu_en_r <= 1'b1;
            busy_r   <= 1'b1;
            done_r   <= 1'b0;
          end
        end
        ST_STEP: begin
          count_r  <= sat_inc(count_r);
          reason_r <= REASON_STEP;
          state_r  <= ST_DONE;
          cpu_en_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b1;
        end
        default: begin
          state_r  <= ST_IDLE;
          cpu_en_r <= 1'b0;
          busy_r   <= 1'b0;
          done_r   <= 1'b0;
        end
      endcase
    end
  end

  assign CpuEn      = cpu_en_r;
  assign Busy       = busy_r;
  assign Done       = done_r;
  assign CycleCount = count_r;
  assign StopReason = reason_r;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed table-driven bench for cpu_run_controller (16-bit and 4-bit counters).
module tb_cpu_run_controller;

  logic        Clock;
  logic        Reset_n;
  logic        Start;
  logic        Step;
  logic [15:0] cycles;
  logic        Abort;
  logic        Halt_in;

  logic        en16, busy16, done16;
  logic [15:0] count16;
  logic [1:0]  reason16;
  logic        en4, busy4, done4;
  logic [3:0]  count4;
  logic [1:0]  reason4;

  int errors = 0;
  int checks = 0;

  cpu_run_controller #(.CNT_W(16), .DEFAULT_CYCLES(4)) dut16 (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Step(Step),
    .Cycles(cycles), .Abort(Abort), .Halt_in(Halt_in),
    .CpuEn(en16), .Busy(busy16), .Done(done16),
    .CycleCount(count16), .StopReason(reason16)
  );

  cpu_run_controller #(.CNT_W(4), .DEFAULT_CYCLES(4)) dut4 (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Step(Step),
    .Cycles(cycles[3:0]), .Abort(Abort), .Halt_in(Halt_in),
    .CpuEn(en4), .Busy(busy4), .Done(done4),
    .CycleCount(count4), .StopReason(reason4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        rst;
    logic        start;
    logic        step;
    logic [15:0] cyc;
    logic        abort;
    logic        halt;
    logic        en;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic [1:0]  reason;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int r, input int st, input int sp, input int c,
                              input int ab, input int h, input int e, input int b,
                              input int d, input int n, input int rs);
    vec_t v;
    v.rst = r[0]; v.start = st[0]; v.step = sp[0]; v.cyc = c[15:0];
    v.abort = ab[0]; v.halt = h[0]; v.en = e[0]; v.busy = b[0]; v.done = d[0];
    v.count = n[15:0]; v.reason = rs[1:0];
    return v;
  endfunction

  function automatic logic [20:0] pack(input logic e, input logic b, input logic d,
                                       input logic [15:0] n, input logic [1:0] rs);
    return {e, b, d, n, rs};
  endfunction

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got en/busy/done/count/reason=%b/%b/%b/%0d/%b exp=%b/%b/%b/%0d/%b",
               name, got[20], got[19], got[18], got[17:2], got[1:0],
               exp[20], exp[19], exp[18], exp[17:2], exp[1:0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic edge_drive(input logic st, input logic sp, input logic [15:0] c,
                            input logic ab, input logic h);
    @(negedge Clock);
    Start = st; Step = sp; cycles = c; Abort = ab; Halt_in = h;
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge Clock);
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge Clock);
    if (v.rst) begin
      Reset_n = 1'b0;
      #2;
      Reset_n = 1'b1;
    end
    Start = v.start; Step = v.step; cycles = v.cyc; Abort = v.abort; Halt_in = v.halt;
    @(posedge Clock);
    #1;
    check($sformatf("vec[%0d]", idx), pack(en16, busy16, done16, count16, reason16),
          pack(v.en, v.busy, v.done, v.count, v.reason));
  endtask

  initial begin
    int en_cnt;
    Reset_n = 1'b0; Start = 1'b0; Step = 1'b0; cycles = 16'd0; Abort = 1'b0; Halt_in = 1'b0;

    // Default-length run, then halt, then abort+halt.
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    for (int j = 1; j <= 3; j++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, j, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0));
    vecs.push_back(mk(0, 1, 0, 10, 0, 0, 1, 1, 0, 0, 0));
    for (int j = 1; j <= 5; j++) vecs.push_back(mk(0, 0, 0, 10, 0, 0, 1, 1, 0, j, 0));
    vecs.push_back(mk(0, 0, 0, 10, 0, 1, 0, 0, 1, 6, 1));
    vecs.push_back(mk(0, 0, 0, 10, 0, 1, 0, 0, 1, 6, 1));
    vecs.push_back(mk(0, 1, 0, 10, 0, 0, 1, 1, 0, 0, 1));
    for (int j = 1; j <= 2; j++) vecs.push_back(mk(0, 0, 0, 10, 0, 0, 1, 1, 0, j, 1));
    vecs.push_back(mk(0, 0, 0, 10, 1, 1, 0, 0, 1, 3, 2));
    vecs.push_back(mk(0, 0, 0, 10, 1, 0, 0, 0, 1, 3, 2));
    // Three steps from reset, then a 2-cycle run.
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 0, 2, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3));
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 1, 1, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 2, 0, 0, 1, 1, 0, 1, 3));
    vecs.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 1, 2, 0));
    // Start and Step together: a run, not a step.
    vecs.push_back(mk(0, 1, 1, 3, 0, 0, 1, 1, 0, 0, 0));
    for (int j = 1; j <= 2; j++) vecs.push_back(mk(0, 0, 0, 3, 0, 0, 1, 1, 0, j, 0));
    vecs.push_back(mk(0, 0, 0, 3, 0, 0, 0, 0, 1, 3, 0));
    // Start held high: DONE lasts one cycle and a new run begins.
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(0, 1, 0, 2, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 1, 2, 0));

    #3;
    check("reset16", pack(en16, busy16, done16, count16, reason16), pack(0, 0, 0, 16'd0, 2'd0));
    check("reset4", pack(en4, busy4, done4, {12'd0, count4}, reason4), pack(0, 0, 0, 16'd0, 2'd0));
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // 4-bit counter: 15-cycle run then two saturating steps.
    pulse_reset();
    Start = 1'b1; cycles = 16'd15;
    @(posedge Clock); #1;
    for (int j = 0; j < 15; j++) edge_drive(1'b0, 1'b0, 16'd15, 1'b0, 1'b0);
    check("w4_run15", pack(en4, busy4, done4, {12'd0, count4}, reason4), pack(0, 0, 1, 16'd15, 2'd0));
    edge_drive(1'b0, 1'b1, 16'd15, 1'b0, 1'b0);
    edge_drive(1'b0, 1'b0, 16'd15, 1'b0, 1'b0);
    edge_drive(1'b0, 1'b1, 16'd15, 1'b0, 1'b0);
    edge_drive(1'b0, 1'b0, 16'd15, 1'b0, 1'b0);
    check("w4_sat", pack(en4, busy4, done4, {12'd0, count4}, reason4), pack(0, 0, 1, 16'd15, 2'd3));
    check("w16_steps", pack(en16, busy16, done16, count16, reason16), pack(0, 0, 1, 16'd17, 2'd3));
    edge_drive(1'b1, 1'b1, 16'd3, 1'b0, 1'b0);
    edge_drive(1'b0, 1'b0, 16'd3, 1'b0, 1'b0);
    check("w4_start_wins", pack(en4, busy4, done4, {12'd0, count4}, reason4), pack(1, 1, 0, 16'd1, 2'd3));
    edge_drive(1'b0, 1'b0, 16'd3, 1'b0, 1'b0);
    edge_drive(1'b0, 1'b0, 16'd3, 1'b0, 1'b0);
    check("w4_run3", pack(en4, busy4, done4, {12'd0, count4}, reason4), pack(0, 0, 1, 16'd3, 2'd0));

    // Asynchronous reset between edges mid-run, then a full 8-cycle run.
    pulse_reset();
    Start = 1'b1; cycles = 16'd8;
    @(posedge Clock); #1;
    for (int j = 0; j < 3; j++) edge_drive(1'b0, 1'b0, 16'd8, 1'b0, 1'b0);
    check("midrun", pack(en16, busy16, done16, count16, reason16), pack(1, 1, 0, 16'd3, 2'd0));
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst", pack(en16, busy16, done16, count16, reason16), pack(0, 0, 0, 16'd0, 2'd0));
    @(negedge Clock);
    Reset_n = 1'b1;
    Start = 1'b1; cycles = 16'd8;
    @(posedge Clock); #1;
    en_cnt = en16 ? 1 : 0;
    for (int j = 0; j < 12; j++) begin
      edge_drive(1'b0, 1'b0, 16'd8, 1'b0, 1'b0);
      if (en16) en_cnt++;
    end
    check_int("en_cycles8", en_cnt, 8);
    check("run8", pack(en16, busy16, done16, count16, reason16), pack(0, 0, 1, 16'd8, 2'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Bounded run/step controller sitting between the board-level clock and the `CPU` top. It generates the CPU clock-enable for an exact number of cycles, for a single step, or until the CPU raises halt. It then parks with a done flag and a cycle count. It is the synthesizable counterpart of the bench's fixed "N clocks then stop" sequence, so the same bring-up program can run on hardware and be observed.

## Interface
- `CNT_W`, 16, width of the cycle limit and cycle counter.
- `DEFAULT_CYCLES`, 4, limit used when `Cycles` is sampled as 0.

- `Clock`  in  1  single system clock; all state updates on its rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  level; sampled in IDLE or DONE, begins a bounded run.
- `Step`  in  1  level; sampled in IDLE or DONE, begins a one-cycle step.
- `Cycles`  in  CNT_W  run length; sampled only on the Start edge.
- `Abort`  in  1  terminates a run; ignored outside RUN.
- `Halt_in`  in  1  CPU halt indication; honoured only in RUN.
- `CpuEn`  out  1  clock-enable to CPU; registered, Moore.
- `Busy`  out  1  high in RUN or STEP.
- `Done`  out  1  high in DONE.
- `CycleCount`  out  CNT_W  number of enabled cycles since the last Start.
- `StopReason`  out  2  00 limit, 01 halt, 10 abort, 11 step.

## Operation
- States: IDLE, RUN, STEP, DONE. Reset → IDLE.
- Reset values: `CpuEn`=0, `Busy`=0, `Done`=0, `CycleCount`=0, `StopReason`=00, internal limit=0.
- IDLE: `CpuEn`=0.
  - `Start`=1 → RUN, `CycleCount`←0, limit←(`Cycles`==0 ? `DEFAULT_CYCLES` : `Cycles`).
  - Else `Step`=1 → STEP.
- RUN: `CpuEn`=1, `Busy`=1. Every edge: `CycleCount`←`CycleCount`+1. Exit to DONE on the first of the following, in priority order:
  - `Abort`=1 → reason 10.
  - `Halt_in`=1 → reason 01.
  - `CycleCount`+1 == limit → reason 00.
  - Otherwise stay in RUN.
  - The cycle on which exit is decided was enabled, so it is counted.
- STEP: `CpuEn`=1, `Busy`=1, for exactly one cycle. On exit: `CycleCount`←`CycleCount`+1, saturating at all-ones; go to DONE with reason 11. The count is not cleared, so repeated steps accumulate.
- DONE: `Done`=1, `CpuEn`=0. `CycleCount` and `StopReason` hold.
  - `Start`=1 → RUN, same actions as from IDLE.
  - Else `Step`=1 → STEP.
  - There is no return to IDLE except by reset.
- `Start` and `Step` asserted together: `Start` wins.
- Holding `Start` high through a run: DONE lasts exactly one cycle, then a new run begins. This is legal and intended.
- `Abort` and `Halt_in` are ignored in IDLE, STEP and DONE.
- Arithmetic:
  - The run counter cannot exceed limit ≤ 2^CNT_W−1, so it never wraps.
  - Only STEP saturates.
  - The limit compare is an equality on CNT_W bits.
- Reset mid-run: asynchronous assertion forces IDLE and drops `CpuEn` immediately, without waiting for `Clock`. The CPU sees no further enabled edge.

## Timing
- `Start` sampled high at edge k, from IDLE with no abort or halt: `CpuEn`=1 for cycles k+1 … k+N (exactly N cycles).
  - `Done` rises after edge k+N.
  - `CycleCount`=N at that point.
- Halt sampled at edge k+j (1 ≤ j ≤ N): `CpuEn` falls after that edge, `CycleCount`=j.
- Step sampled at edge k: `CpuEn`=1 for the single cycle k+1. `Done` is high after edge k+1.
- No combinational path from any input to any output.
- Reset release: the first edge after `Reset_n` rises may already sample `Start`.

## Test plan
- Reset, then `Cycles`=0, `Start` pulsed 1 cycle → `CpuEn` high for exactly 4 cycles, then `Done`=1, `CycleCount`=4, `StopReason`=00.
- `Cycles`=10, `Start`; `Halt_in` high at the 6th enabled cycle → `CpuEn` drops after that edge, `CycleCount`=6, `StopReason`=01. A halt asserted in DONE is ignored.
- `Cycles`=10, `Start`; `Abort` and `Halt_in` high together at the 3rd enabled cycle → `CycleCount`=3, `StopReason`=10.
- Three `Step` pulses separated by idle gaps, starting from reset → three single-cycle `CpuEn` pulses, `CycleCount`=3, `StopReason`=11. A following `Start` with `Cycles`=2 → `CycleCount`=2.
- `CNT_W`=4: run with `Cycles`=15, then 2 steps → `CycleCount`=15 (saturated). Also `Start` and `Step` asserted together → a run occurs, not a step.
- `Reset_n` asserted between edges mid-run (`Cycles`=8, after 3 enabled cycles) → `CpuEn`, `Busy`, `CycleCount` all 0 immediately. After release and `Start`, a full 8-cycle run completes.
